keccak_round_ctrl: RTL and testbench

Sequencer for the slice-parallel Keccak state RAM. It drives the RAM control inputs `raddr`, `we`, `absorb`, `bof`, `first_round`, `last_round`, `load_hash` and `computation_en` through absorb, permutation and squeeze phases. It accepts rate-sized message blocks over a valid/ready stream and runs the 24-round Keccak-f[1600] permutation as NUM_SUB_ROUNDS slice-group beats per round. It exposes squeezed output over a second valid/ready stream. It sits between the SHAKE256 front end and the state RAM/round datapath.

---
 rtl/keccak_pkg.sv | 29 ++
 rtl/keccak_sweep_cnt.sv | 30 +++
 rtl/keccak_round_ctrl.sv | 142 ++++++++++++++
 tb/tb_keccak_round_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak round sequencer: FSM encoding, round count,
// sweep-length derivation and the all-lanes write mask.
package keccak_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ABSORB  = 2'd1;
    localparam logic [1:0] S_PERMUTE = 2'd2;
    localparam logic [1:0] S_SQUEEZE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = S_IDLE,
        ST_ABSORB  = S_ABSORB,
        ST_PERMUTE = S_PERMUTE,
        ST_SQUEEZE = S_SQUEEZE
    } ctrl_state_e;

    localparam int NUM_ROUNDS = 24;
    localparam logic [24:0] ALL_LANES = 25'h1FFFFFF;

    // 64 slices per lane, PARALLEL_SLICES of them handled per beat.
    function automatic int num_sub_rounds(input int parallel_slices);
        return 64 / parallel_slices;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/keccak_sweep_cnt.sv
// Enable-gated modulo-N counter; wrap is high on the enabled beat that returns
// the count to zero.
module keccak_sweep_cnt
    import keccak_pkg::*;
#(
    parameter int N = 4,
    parameter int W = cnt_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = en && (cnt == W'(N - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/keccak_round_ctrl.sv
// Absorb / permute / squeeze sequencer for the slice-parallel Keccak state RAM.
// Optional KECCAK_CTRL_PERF_CNT_EN adds a free-running permutation counter.
module keccak_round_ctrl
    import keccak_pkg::*;
#(
    parameter int PARALLEL_SLICES = 16,
    parameter int NUM_SUB_ROUNDS  = num_sub_rounds(PARALLEL_SLICES),
    parameter int NUM_ROUNDS      = keccak_pkg::NUM_ROUNDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        squeeze_more,
    output logic [31:0] raddr,
    output logic [24:0] we,
    output logic        absorb,
    output logic        bof,
    output logic        first_round,
    output logic        last_round,
    output logic        load_hash,
    output logic        computation_en,
    output logic [4:0]  round_idx,
    output logic        busy,
    output logic        done
`ifdef KECCAK_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] perm_count
`endif
);

    localparam int CW = cnt_width(NUM_SUB_ROUNDS);

    ctrl_state_e   state;
    logic [CW-1:0] cnt;
    logic          cnt_en, cnt_wrap;
    logic          in_fire, out_fire, perm_end, round_last;
    logic [4:0]    round_q;
    logic          last_blk_q, bof_q, done_q;
    logic [24:0]   we_q;

    assign in_fire    = (state == ST_ABSORB) && in_valid;
    assign out_fire   = (state == ST_SQUEEZE) && out_ready;
    assign cnt_en     = in_fire || out_fire || (state == ST_PERMUTE);
    assign round_last = (round_q == 5'(NUM_ROUNDS - 1));
    assign perm_end   = (state == ST_PERMUTE) && cnt_wrap && round_last;

    keccak_sweep_cnt #(.N(NUM_SUB_ROUNDS), .W(CW)) u_sweep (
        .clk  (clk),
        .rst  (rst),
        .en   (cnt_en),
        .cnt  (cnt),
        .wrap (cnt_wrap)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            round_q    <= '0;
            last_blk_q <= 1'b0;
            bof_q      <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= '0;
        end else begin
            done_q <= 1'b0;
            // Writes land one cycle after the slice group was read.
            we_q   <= (in_fire || (state == ST_PERMUTE)) ? ALL_LANES : '0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_ABSORB;
                        bof_q <= 1'b1;
                    end
                end
                ST_ABSORB: begin
                    if (in_fire && cnt_wrap) begin
                        bof_q      <= 1'b0;
                        last_blk_q <= in_last;
                        state      <= ST_PERMUTE;
                    end
                end
                ST_PERMUTE: begin
                    if (cnt_wrap) begin
                        if (round_last) begin
                            round_q <= '0;
                            state   <= last_blk_q ? ST_SQUEEZE : ST_ABSORB;
                        end else begin
                            round_q <= round_q + 5'd1;
                        end
                    end
                end
                ST_SQUEEZE: begin
                    if (out_fire && cnt_wrap) begin
                        if (squeeze_more) begin
                            state <= ST_PERMUTE;
                        end else begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready       = (state == ST_ABSORB);
    assign absorb         = (state == ST_ABSORB);
    assign computation_en = (state == ST_PERMUTE);
    assign load_hash      = (state == ST_SQUEEZE);
    assign out_valid      = (state == ST_SQUEEZE);
    assign busy           = (state != ST_IDLE);
    assign raddr          = 32'(cnt);
    assign we             = we_q;
    assign bof            = bof_q;
    assign done           = done_q;
    assign round_idx      = round_q;
    assign first_round    = (state == ST_PERMUTE) && (round_q == 5'd0);
    assign last_round     = (state == ST_PERMUTE) && round_last;

`ifdef KECCAK_CTRL_PERF_CNT_EN
    logic [31:0] perm_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            perm_cnt_q <= '0;
        end else if (perm_end) begin
            perm_cnt_q <= perm_cnt_q + 32'd1;
        end
    end

    assign perm_count = perm_cnt_q;
`else
    logic unused_perm_end;
    assign unused_perm_end = perm_end;
`endif

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Directed bench for keccak_round_ctrl: scoreboarded absorb/squeeze addresses,
// per-cycle permutation model, reset and stall scenarios.
module tb_keccak_round_ctrl;

    localparam int PS  = 16;
    localparam int NSR = 64 / PS;
    localparam int NR  = 24;
    localparam logic [24:0] ALL = 25'h1FFFFFF;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_last, out_ready, squeeze_more;
    logic        in_ready, out_valid, absorb, bof, first_round, last_round;
    logic        load_hash, computation_en, busy, done;
    logic [31:0] raddr;
    logic [24:0] we;
    logic [4:0]  round_idx;
`ifdef KECCAK_CTRL_PERF_CNT_EN
    logic [31:0] perm_count;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;
    int perms   = 0;
    int sb_q[$];

    always #5 clk = ~clk;

    keccak_round_ctrl #(.PARALLEL_SLICES(PS)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_last        (in_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .squeeze_more   (squeeze_more),
        .raddr          (raddr),
        .we             (we),
        .absorb         (absorb),
        .bof            (bof),
        .first_round    (first_round),
        .last_round     (last_round),
        .load_hash      (load_hash),
        .computation_en (computation_en),
        .round_idx      (round_idx),
        .busy           (busy),
        .done           (done)
`ifdef KECCAK_CTRL_PERF_CNT_EN
        ,
        .perm_count     (perm_count)
`endif
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] outs();
        return {in_ready, out_valid, raddr, we, absorb, bof, first_round, last_round,
                load_hash, computation_en, round_idx, busy, done};
    endfunction

    // Drives one block; entered on the first ABSORB cycle.
    task automatic absorb_block(input bit last, input bit bof_exp, input bit toggle,
                                input logic [24:0] we0);
        int beats = 0;
        int c = 0;
        logic [24:0] we_exp = we0;
        bit v;
        while (beats < NSR && c < 100) begin
            v        = toggle ? (c % 2 == 1) : 1'b1;
            in_valid = v;
            in_last  = last && (beats == NSR - 1);
            if (v) sb_q.push_back(beats);
            check("abs_ctrl", {in_ready, absorb, bof, busy, computation_en, we},
                  {1'b1, 1'b1, bof_exp, 1'b1, 1'b0, we_exp});
            check("abs_raddr", raddr, beats);
            if (v && in_ready) begin
                check("abs_beat", raddr, sb_q.pop_front());
                beats++;
                we_exp = ALL;
            end else begin
                we_exp = '0;
            end
            c++;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("abs_beats_done", beats, NSR);
    endtask

    // Entered on the first PERMUTE cycle; optionally pulses start mid-way.
    task automatic perm_phase(input logic [24:0] we0, input bit pulse_start);
        int n = 0;
        while (computation_en === 1'b1 && n < 200) begin
            start = pulse_start && (n == 10);
            check("perm_cycle", {raddr, round_idx, first_round, last_round, we},
                  {32'(n % NSR), 5'(n / NSR), (n < NSR), (n >= (NR - 1) * NSR),
                   (n == 0) ? we0 : ALL});
            n++;
            tick();
        end
        start = 1'b0;
        check("perm_len", n, NR * NSR);
        check("perm_trail_we", we, ALL);
        if (n == NR * NSR) perms++;
    endtask

    // Entered on the first SQUEEZE cycle.
    task automatic squeeze_sweep(input int stall_at, input int stall_len, input bit more);
        int beats = 0;
        int c = 0;
        int stalled = 0;
        bit rdy;
        for (int i = 0; i < NSR; i++) sb_q.push_back(i);
        while (beats < NSR && c < 100) begin
            rdy = 1'b1;
            if (beats == stall_at && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end
            out_ready    = rdy;
            squeeze_more = more;
            check("sq_ctrl", {out_valid, load_hash, in_ready, computation_en, done, we},
                  {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, (c == 0) ? ALL : 25'd0});
            check("sq_raddr", raddr, (sb_q.size() > 0) ? sb_q[0] : -1);
            if (out_valid && rdy) begin
                void'(sb_q.pop_front());
                beats++;
            end
            c++;
            tick();
        end
        out_ready    = 1'b0;
        squeeze_more = 1'b0;
        check("sq_beats_done", beats, NSR);
        check("sq_cycles", c, NSR + ((stall_at < NSR) ? stall_len : 0));
        if (more) begin
            check("sq_more_perm", {computation_en, busy, done}, {3'b110});
        end else begin
            check("done_pulse", {busy, done, out_valid}, {3'b010});
            tick();
            check("idle_after_done", outs(), '0);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b0; squeeze_more = 1'b0;
        tick();
        tick();
        check("reset_outs", outs(), '0);
        rst = 1'b1;
        tick();
        check("idle_outs", outs(), '0);

        // Single block, one squeeze sweep.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_to_ready", {in_ready, bof, busy, raddr}, {3'b111, 32'd0});
        absorb_block(1'b1, 1'b1, 1'b0, '0);
        perm_phase(ALL, 1'b0);
        squeeze_sweep(NSR, 0, 1'b0);

        // Two blocks (first with gapped valid), stalled squeeze, extra squeeze.
        start = 1'b1;
        tick();
        start = 1'b0;
        absorb_block(1'b0, 1'b1, 1'b1, '0);
        perm_phase(ALL, 1'b1);
        check("second_block_bof", {in_ready, bof}, {2'b10});
        absorb_block(1'b1, 1'b0, 1'b0, ALL);
        perm_phase(ALL, 1'b0);
        squeeze_sweep(2, 3, 1'b1);
        perm_phase('0, 1'b0);
        squeeze_sweep(NSR, 0, 1'b0);
        check("perm_total", perms, 4);
`ifdef KECCAK_CTRL_PERF_CNT_EN
        check("perm_count", perm_count, perms);
`endif

        // Reset in the middle of round 7, then valid outside ABSORB.
        start = 1'b1;
        tick();
        start = 1'b0;
        absorb_block(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 200 && !(round_idx == 5'd7 && raddr == 32'd2); i++) tick();
        check("reached_round7", {computation_en, round_idx}, {1'b1, 5'd7});
        rst = 1'b0;
        tick();
        check("rst_mid_perm", outs(), '0);
        rst      = 1'b1;
        in_valid = 1'b1;
        tick();
        check("idle_ignores_valid", outs(), '0);
        in_valid = 1'b0;
`ifdef KECCAK_CTRL_PERF_CNT_EN
        check("perm_count_reset", perm_count, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
